pixel_out_fifo: RTL and testbench

Parametrised output stage for the RGB-to-gray pixel path, replacing the single enable-loaded output register with a small first-word-fall-through FIFO. It buffers converted pixels between the gray converter and the downstream consumer, uses a valid/ready handshake on the read side, and provides a synchronous active-low flush. It also reports fill level, almost-full and a sticky overflow flag. It sits at the tail of the conversion pipeline, directly in front of the output interface.

---
 rtl/pixel_out_fifo.sv | 116 +++++++++++
 tb/tb_pixel_out_fifo.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_out_fifo.sv
// pixel_out_fifo
// First-word-fall-through output FIFO at the tail of the RGB-to-gray
// pixel path. It buffers converted pixels for the downstream consumer.
//
// Parameters
//   WIDTH        pixel data width in bits
//   DEPTH        number of entries (power of two, >= 2)
//   AFULL_LEVEL  occupancy at or above which Almost_Full asserts
//
// Ports
//   CLK          single clock, rising edge
//   RESET        asynchronous active-high reset
//   CLEAR        synchronous active-low flush
//   In_Valid     push request (never held by the converter)
//   Data_In      pixel to push
//   In_Ready     advisory, high when not full
//   Out_Valid    head entry present
//   Out_Ready    consumer accepts the head entry this cycle
//   Data_Out     head entry, forced to 0 when empty
//   Count        current occupancy, 0..DEPTH
//   Almost_Full  Count >= AFULL_LEVEL
//   Overflow     sticky, set when a push was dropped
module pixel_out_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       CLEAR,
    input  logic                       In_Valid,
    input  logic [WIDTH-1:0]           Data_In,
    output logic                       In_Ready,
    output logic                       Out_Valid,
    input  logic                       Out_Ready,
    output logic [WIDTH-1:0]           Data_Out,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Almost_Full,
    output logic                       Overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic do_write;
    logic drop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    assign push = In_Valid;
    assign pop  = ~empty & Out_Ready;

    // When full, a push still lands if a pop frees the head slot on the
    // same edge; only an unaccompanied push into a full FIFO is dropped.
    assign do_write = push & (~full | pop);
    assign drop     = push & full & ~pop;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else if (!CLEAR) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_write, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage has no reset; a flush only needs the pointers cleared, but
    // the write is still suppressed so a flushed push leaves no trace.
    always_ff @(posedge CLK) begin
        if (!RESET && CLEAR && do_write) begin
            mem[wr_ptr] <= Data_In;
        end
    end

    assign In_Ready    = ~full;
    assign Out_Valid   = ~empty;
    assign Data_Out    = empty ? '0 : mem[rd_ptr];
    assign Count       = count;
    assign Almost_Full = (count >= AFULL_CNT);
    assign Overflow    = overflow_q;

endmodule

// File: tb/tb_pixel_out_fifo.sv
// tb_pixel_out_fifo
// Self-checking bench for pixel_out_fifo. Two instances are exercised:
// dutA with the default 8-bit x 4 configuration and dutB with 12-bit x 8
// and AFULL_LEVEL=6. A queue model per instance holds the expected
// contents; entries are pushed when stimulus is driven and compared at
// the head every cycle as the DUT presents them.
module tb_pixel_out_fifo;

    logic clk;
    logic reset;

    logic        clrA, inValidA, inReadyA, outValidA, outReadyA, afA, ovfA;
    logic [7:0]  dataInA, dataOutA;
    logic [2:0]  countA;

    logic        clrB, inValidB, inReadyB, outValidB, outReadyB, afB, ovfB;
    logic [11:0] dataInB, dataOutB;
    logic [3:0]  countB;

    logic [15:0] qA[$];
    logic [15:0] qB[$];
    bit          ovfModelA;
    bit          ovfModelB;

    int checks;
    int errors;

    pixel_out_fifo #(.WIDTH(8), .DEPTH(4), .AFULL_LEVEL(3)) dutA (
        .CLK(clk), .RESET(reset), .CLEAR(clrA),
        .In_Valid(inValidA), .Data_In(dataInA), .In_Ready(inReadyA),
        .Out_Valid(outValidA), .Out_Ready(outReadyA), .Data_Out(dataOutA),
        .Count(countA), .Almost_Full(afA), .Overflow(ovfA)
    );

    pixel_out_fifo #(.WIDTH(12), .DEPTH(8), .AFULL_LEVEL(6)) dutB (
        .CLK(clk), .RESET(reset), .CLEAR(clrB),
        .In_Valid(inValidB), .Data_In(dataInB), .In_Ready(inReadyB),
        .Out_Valid(outValidB), .Out_Ready(outReadyB), .Data_Out(dataOutB),
        .Count(countB), .Almost_Full(afB), .Overflow(ovfB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Compares every output of one instance against its queue model.
    task automatic checkState(input int dut);
        logic [15:0] m[$];
        int          depth, afl, n;
        bit          ovfExp;
        logic [31:0] oCount, oValid, oData, oReady, oAf, oOvf;
        if (dut == 0) begin
            m = qA; depth = 4; afl = 3; ovfExp = ovfModelA;
            oCount = 32'(countA); oValid = 32'(outValidA); oData = 32'(dataOutA);
            oReady = 32'(inReadyA); oAf = 32'(afA); oOvf = 32'(ovfA);
        end else begin
            m = qB; depth = 8; afl = 6; ovfExp = ovfModelB;
            oCount = 32'(countB); oValid = 32'(outValidB); oData = 32'(dataOutB);
            oReady = 32'(inReadyB); oAf = 32'(afB); oOvf = 32'(ovfB);
        end
        n = m.size();
        checkOutput(dut == 0 ? "A.count" : "B.count", oCount, 32'(n));
        checkOutput(dut == 0 ? "A.out_valid" : "B.out_valid", oValid, 32'(n != 0));
        checkOutput(dut == 0 ? "A.data_out" : "B.data_out", oData,
                    (n != 0) ? 32'(m[0]) : 32'd0);
        checkOutput(dut == 0 ? "A.in_ready" : "B.in_ready", oReady, 32'(n != depth));
        checkOutput(dut == 0 ? "A.almost_full" : "B.almost_full", oAf, 32'(n >= afl));
        checkOutput(dut == 0 ? "A.overflow" : "B.overflow", oOvf, 32'(ovfExp));
    endtask

    // One clock cycle on one instance: check outputs at the falling edge,
    // drive the inputs for the next rising edge, and advance the model.
    task automatic applyStimulus(input int dut, input logic valid,
                                 input logic [15:0] data, input logic ready,
                                 input logic clr);
        logic [15:0] m[$];
        int          depth;
        bit          ovf, popNow, wasFull;
        @(negedge clk);
        checkState(dut);
        inValidA = 1'b0; outReadyA = 1'b0; clrA = 1'b1;
        inValidB = 1'b0; outReadyB = 1'b0; clrB = 1'b1;
        if (dut == 0) begin
            inValidA = valid; dataInA = data[7:0]; outReadyA = ready; clrA = clr;
            m = qA; ovf = ovfModelA; depth = 4;
        end else begin
            inValidB = valid; dataInB = data[11:0]; outReadyB = ready; clrB = clr;
            m = qB; ovf = ovfModelB; depth = 8;
        end
        if (!clr) begin
            m.delete();
            ovf = 1'b0;
        end else begin
            popNow  = (m.size() != 0) && ready;
            wasFull = (m.size() == depth);
            if (popNow) void'(m.pop_front());
            if (valid) begin
                if (!wasFull || popNow) m.push_back(data);
                else ovf = 1'b1;
            end
        end
        if (dut == 0) begin qA = m; ovfModelA = ovf; end
        else begin qB = m; ovfModelB = ovf; end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ovfModelA = 1'b0;
        ovfModelB = 1'b0;
        reset = 1'b1;
        clrA = 1'b1; inValidA = 1'b0; dataInA = '0; outReadyA = 1'b0;
        clrB = 1'b1; inValidB = 1'b0; dataInB = '0; outReadyB = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkState(0);
        checkState(1);

        $display("[TB] fill and drain");
        applyStimulus(0, 1, 16'h11, 0, 1);
        applyStimulus(0, 1, 16'h22, 0, 1);
        applyStimulus(0, 1, 16'h33, 0, 1);
        applyStimulus(0, 1, 16'h44, 0, 1);
        repeat (4) applyStimulus(0, 0, 16'h0, 1, 1);
        applyStimulus(0, 0, 16'h0, 0, 1);

        $display("[TB] push and pop while full");
        for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 16'(i * 'h11), 0, 1);
        applyStimulus(0, 1, 16'h55, 1, 1);
        repeat (4) applyStimulus(0, 0, 16'h0, 1, 1);
        applyStimulus(0, 0, 16'h0, 0, 1);

        $display("[TB] overflow and flush");
        for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 16'(i * 'h11), 0, 1);
        applyStimulus(0, 1, 16'h66, 0, 1);
        applyStimulus(0, 0, 16'h0, 0, 1);
        repeat (4) applyStimulus(0, 0, 16'h0, 1, 1);
        applyStimulus(0, 1, 16'h77, 0, 1);
        applyStimulus(0, 1, 16'h88, 1, 0);
        applyStimulus(0, 0, 16'h0, 0, 1);

        $display("[TB] streaming with wrap-around");
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 16'(i), (i >= 1), 1);
        applyStimulus(0, 0, 16'h0, 1, 1);
        applyStimulus(0, 0, 16'h0, 0, 1);

        $display("[TB] async reset mid-operation");
        applyStimulus(0, 1, 16'hA1, 0, 1);
        applyStimulus(0, 1, 16'hA2, 0, 1);
        applyStimulus(0, 1, 16'hA3, 0, 1);
        @(negedge clk);
        checkState(0);
        inValidA = 1'b0;
        #1 reset = 1'b1;
        #1;
        qA.delete(); qB.delete();
        ovfModelA = 1'b0; ovfModelB = 1'b0;
        checkState(0);
        checkState(1);
        #1 reset = 1'b0;
        applyStimulus(0, 1, 16'hB1, 0, 1);
        applyStimulus(0, 0, 16'h0, 1, 1);
        applyStimulus(0, 0, 16'h0, 0, 1);

        $display("[TB] wide/deep instance fill, overflow, drain");
        for (int i = 0; i < 8; i++) applyStimulus(1, 1, 16'('h100 + i * 'h111), 0, 1);
        applyStimulus(1, 1, 16'hABC, 0, 1);
        applyStimulus(1, 1, 16'hDEF, 1, 1);
        repeat (8) applyStimulus(1, 0, 16'h0, 1, 1);
        applyStimulus(1, 0, 16'h0, 0, 1);

        @(negedge clk);
        checkState(0);
        checkState(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
